// File: rtl/packet_queue.sv
// Circular packet queue between the upstream flit buffer and the WISHBONE message stage.
// Optional push statistics counter enabled by defining PKT_QUEUE_STATS_EN.

`ifndef MAX_PACKET_LENGHT
`define MAX_PACKET_LENGHT 4
`endif
`ifndef FLIT_WIDTH
`define FLIT_WIDTH 8
`endif

module packet_queue #(
  parameter int N_BITS_DEPTH = 2
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic                                        r_pkt_to_msg_i,
  input  logic [`MAX_PACKET_LENGHT*`FLIT_WIDTH-1:0]   in_link_i,
  output logic                                        g_pkt_to_msg_o,
  output logic                                        r_msg_o,
  input  logic                                        g_msg_i,
  output logic [`MAX_PACKET_LENGHT*`FLIT_WIDTH-1:0]   out_link_o,
  output logic [N_BITS_DEPTH:0]                       count_o
`ifdef PKT_QUEUE_STATS_EN
  ,
  output logic [15:0]                                 pkt_count_o
`endif
);

  localparam int PKT_W = `MAX_PACKET_LENGHT * `FLIT_WIDTH;
  localparam int DEPTH = 1 << N_BITS_DEPTH;
  localparam logic [N_BITS_DEPTH:0] DEPTH_C = (N_BITS_DEPTH + 1)'(DEPTH);

  logic [PKT_W-1:0]        mem [DEPTH];
  logic [N_BITS_DEPTH-1:0] wr_ptr;
  logic [N_BITS_DEPTH-1:0] rd_ptr;
  logic [N_BITS_DEPTH:0]   count;
  logic                    full;
  logic                    empty;
  logic                    push;
  logic                    pop;

  // Grant is blocked while full even if a pop happens this cycle: no fall-through.
  always_comb begin
    full           = (count == DEPTH_C);
    empty          = (count == '0);
    g_pkt_to_msg_o = r_pkt_to_msg_i & ~full & rst;
    push           = r_pkt_to_msg_i & g_pkt_to_msg_o;
    r_msg_o        = ~empty;
    pop            = g_msg_i & r_msg_o;
    out_link_o     = mem[rd_ptr];
    count_o        = count;
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= in_link_i;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

`ifdef PKT_QUEUE_STATS_EN
  logic [15:0] pkt_count;

  always_ff @(posedge clk) begin
    if (!rst) begin
      pkt_count <= '0;
    end else if (push && (pkt_count != 16'hFFFF)) begin
      pkt_count <= pkt_count + 16'd1;
    end
  end

  assign pkt_count_o = pkt_count;
`endif

endmodule

// File: tb/tb_packet_queue.sv
// Directed scoreboard bench for packet_queue: expected packets are queued on push and
// compared against out_link_o on pop.

`ifndef MAX_PACKET_LENGHT
`define MAX_PACKET_LENGHT 4
`endif
`ifndef FLIT_WIDTH
`define FLIT_WIDTH 8
`endif

module tb_packet_queue;

  localparam int N_BITS_DEPTH = 2;
  localparam int DEPTH = 1 << N_BITS_DEPTH;
  localparam int PKT_W = `MAX_PACKET_LENGHT * `FLIT_WIDTH;

  logic                  clk;
  logic                  rst;
  logic                  r_pkt_to_msg_i;
  logic [PKT_W-1:0]      in_link_i;
  logic                  g_pkt_to_msg_o;
  logic                  r_msg_o;
  logic                  g_msg_i;
  logic [PKT_W-1:0]      out_link_o;
  logic [N_BITS_DEPTH:0] count_o;
`ifdef PKT_QUEUE_STATS_EN
  logic [15:0]           pkt_count_o;
  int                    model_pkt;
`endif

  logic [PKT_W-1:0] sb[$];
  int               model_count;
  int               checks;
  int               errors;

  packet_queue #(.N_BITS_DEPTH(N_BITS_DEPTH)) dut (
    .clk            (clk),
    .rst            (rst),
    .r_pkt_to_msg_i (r_pkt_to_msg_i),
    .in_link_i      (in_link_i),
    .g_pkt_to_msg_o (g_pkt_to_msg_o),
    .r_msg_o        (r_msg_o),
    .g_msg_i        (g_msg_i),
    .out_link_o     (out_link_o),
    .count_o        (count_o)
`ifdef PKT_QUEUE_STATS_EN
    ,
    .pkt_count_o    (pkt_count_o)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_output();
    check_eq("count_o", 64'(count_o), 64'(model_count));
    check_eq("r_msg_o", 64'(r_msg_o), 64'(model_count > 0));
    if (sb.size() > 0) begin
      check_eq("out_link_head", 64'(out_link_o), 64'(sb[0]));
    end
`ifdef PKT_QUEUE_STATS_EN
    check_eq("pkt_count_o", 64'(pkt_count_o), 64'(model_pkt));
`endif
  endtask

  // One clock cycle: drive inputs, check grant and popped packet mid-cycle, update model.
  task automatic apply_stimulus(input logic req, input logic [PKT_W-1:0] data,
                                input logic gnt, input logic rs);
    logic exp_grant;
    logic do_pop;
    r_pkt_to_msg_i = req;
    in_link_i      = data;
    g_msg_i        = gnt;
    rst            = rs;
    @(negedge clk);
    exp_grant = req && rs && (model_count < DEPTH);
    do_pop    = gnt && rs && (model_count > 0);
    check_eq("grant", 64'(g_pkt_to_msg_o), 64'(exp_grant));
    if (do_pop) begin
      check_eq("popped_pkt", 64'(out_link_o), 64'(sb[0]));
    end
    @(posedge clk);
    if (!rs) begin
      sb.delete();
`ifdef PKT_QUEUE_STATS_EN
      model_pkt = 0;
`endif
    end else begin
      if (do_pop) void'(sb.pop_front());
      if (exp_grant) begin
        sb.push_back(data);
`ifdef PKT_QUEUE_STATS_EN
        if (model_pkt != 65535) model_pkt++;
`endif
      end
    end
    model_count = sb.size();
    #1;
    check_output();
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    model_count = 0;
`ifdef PKT_QUEUE_STATS_EN
    model_pkt   = 0;
`endif

    // Reset with no traffic
    apply_stimulus(1'b0, '0, 1'b0, 1'b0);
    apply_stimulus(1'b0, '0, 1'b0, 1'b0);

    // Single packet through, one cycle latency
    apply_stimulus(1'b1, 32'hA1A1_0001, 1'b0, 1'b1);
    apply_stimulus(1'b0, '0, 1'b0, 1'b1);
    apply_stimulus(1'b0, '0, 1'b1, 1'b1);
    // Pop request while empty is ignored
    apply_stimulus(1'b0, '0, 1'b1, 1'b1);

    // Fill to depth, fifth request blocked even across the first pop
    for (int i = 1; i <= 4; i++) apply_stimulus(1'b1, 32'hB000_0000 + 32'(i), 1'b0, 1'b1);
    apply_stimulus(1'b1, 32'hB000_0005, 1'b0, 1'b1);
    apply_stimulus(1'b1, 32'hB000_0005, 1'b1, 1'b1);
    apply_stimulus(1'b1, 32'hB000_0005, 1'b0, 1'b1);
    while (model_count > 0) apply_stimulus(1'b0, '0, 1'b1, 1'b1);

    // Simultaneous push and pop with two stored
    apply_stimulus(1'b1, 32'hC000_0001, 1'b0, 1'b1);
    apply_stimulus(1'b1, 32'hC000_0002, 1'b0, 1'b1);
    apply_stimulus(1'b1, 32'hC000_0003, 1'b1, 1'b1);
    while (model_count > 0) apply_stimulus(1'b0, '0, 1'b1, 1'b1);

    // Pointer wrap with mixed push/pop traffic
    for (int i = 0; i < 24; i++) begin
      apply_stimulus(1'($urandom_range(0, 1)), PKT_W'($urandom), 1'($urandom_range(0, 1)), 1'b1);
    end
    while (model_count > 0) apply_stimulus(1'b0, '0, 1'b1, 1'b1);

    // Reset mid-operation with three stored and a pending request
    for (int i = 1; i <= 3; i++) apply_stimulus(1'b1, 32'hD000_0000 + 32'(i), 1'b0, 1'b1);
    apply_stimulus(1'b1, 32'hE000_0001, 1'b0, 1'b0);
    apply_stimulus(1'b1, 32'hE000_0001, 1'b0, 1'b1);
    apply_stimulus(1'b0, '0, 1'b1, 1'b1);

`ifdef PKT_QUEUE_STATS_EN
    apply_stimulus(1'b0, '0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) apply_stimulus(1'b1, PKT_W'(i), 1'b1, 1'b1);
    check_eq("stats_after_5", 64'(pkt_count_o), 64'd5);
    for (int i = 0; i < 65540; i++) apply_stimulus(1'b1, PKT_W'(i), 1'b1, 1'b1);
    check_eq("stats_saturate", 64'(pkt_count_o), 64'hFFFF);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
